nn_core_param: RTL and testbench
================================

Name: nn_core_param

Overview:
- Parametrised two-layer fully-connected inference engine. It is the next generation of the fixed 784-32-10 spiking/MLP core.
- Computes N_HID hidden activations from N_IN pixels, then N_OUT output activations, and reports the signed argmax as the classified digit.
- Reads pixels, weights and the activation LUT from external synchronous memories. The hidden-unit buffer and argmax tracking are internal.
- Sits between the image RAM/UART loader and the digit display/transmit logic.

Parameters:
N_IN, 784, number of input pixels
N_HID, 32, number of hidden units
N_OUT, 10, number of output units
PIX_W, 1, pixel width in bits (1..7)
ACC_W, 26, accumulator width; must be >= 16+$clog2(max(N_IN,N_HID))

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin inference (sampled in IDLE only)
in_addr  out  $clog2(N_IN)  pixel memory address
in_data  in  PIX_W  pixel data, unsigned
hw_addr  out  $clog2(N_IN*N_HID)  hidden weight address = h*N_IN+i
hw_data  in  8  hidden weight, signed
ow_addr  out  $clog2(N_HID*N_OUT)  output weight address = o*N_HID+h
ow_data  in  8  output weight, signed
act_addr  out  11  activation LUT address
act_data  in  8  activation LUT data, signed
busy  out  1  inference in progress
done  out  1  result valid; held until next accepted start
digit  out  $clog2(N_OUT)  argmax index
digit_val  out  8  activation value at argmax, signed

Behaviour:
- One clock domain. Reset is asynchronous and active-low. Port names are clk and rst_n.
- Reset values: all outputs 0, state IDLE, accumulator 0, max register -128.
- All external memories are synchronous reads: an address driven in cycle t returns data in cycle t+1. All address outputs are registered.
- Pixel extension: PIX_W=1 maps 1 to 127 and 0 to 0. PIX_W>1 is left-aligned zero-padded to 7 bits, with the sign bit 0.
- MAC: acc <= acc + sext(a)*sext(b) (8x8 signed) in the cycle data is valid. No internal overflow checking.
- Rectify and index: s = acc>>>7, saturated to the 11-bit signed range [-1024, 1023]. act_addr = s + 1024 (mod 2048), combinational from acc.
- States and transitions:
  - IDLE: if start, clear counters, acc and max (max = -128, index 0), set busy, drop done, go to HID_MAC.
  - HID_MAC: issue in_addr=i and hw_addr=h*N_IN+i for i = 0..N_IN-1, one per cycle. Go to HID_DRAIN after the last issue.
  - HID_DRAIN: accumulate the final product (1 cycle), go to HID_ACT.
  - HID_ACT: act_addr is valid (1 cycle), go to HID_WR.
  - HID_WR: hid_buf[h] <= act_data, clear acc, h++. If h was N_HID-1, go to OUT_MAC; else go to HID_MAC.
  - OUT_MAC: operands are hid_buf[h] and ow_data, with ow_addr=o*N_HID+h for h = 0..N_HID-1. The hid_buf read is registered, aligned with ow_data.
  - OUT_DRAIN, then OUT_ACT: same timing as the hidden-layer equivalents.
  - OUT_CMP: if signed act_data > max (strict), update max and index. Clear acc, o++. If o was N_OUT-1, go to DONE; else go to OUT_MAC.
  - DONE: done=1, busy=0, digit=index, digit_val=max. Go to IDLE the same cycle.
- done and digit stay stable in IDLE until the next start is accepted.
- Latency: done rises exactly L = N_HID*(N_IN+3) + N_OUT*(N_HID+3) + 1 cycles after the start-sampling edge. Default L = 25535.
- Boundary conditions:
  - Ties: the lowest index wins.
  - All outputs equal to -128: digit=0.
  - start while busy is ignored.
  - start held high across DONE launches a new run in the following IDLE cycle.
  - Reset mid-run aborts immediately and returns all outputs to their reset values.
  - Address counters wrap to 0 at each layer start; they never exceed N-1.

Decomposition:
- Package nn_pkg holds:
  - state_t enum: IDLE, HID_MAC, HID_DRAIN, HID_ACT, HID_WR, OUT_MAC, OUT_DRAIN, OUT_ACT, OUT_CMP, DONE.
  - Constants: ACT_LUT_AW=11, ACT_OFFSET=1024, MAX_INIT=-128, PIX_ONE=127.
- Sub-module nn_mac_rect holds the signed MAC, the accumulator clear and the saturating act_addr generation, parametrised by ACC_W.
- The argmax register, hidden buffer and FSM remain in nn_core_param.

Test Plan:
- Identity LUT (act_data = addr-1024, clipped to 8-bit). N_IN=4, N_HID=2, N_OUT=3, PIX_W=1. All pixels 1, all weights 1. Per-neuron hidden acc = 4*127 = 508, act 3. Expect done after L = 2*7 + 3*5 + 1 = 30 cycles, digit=0 (ties), digit_val = (2*3*1)>>>7 = 0.
- Default params with random pixels and weights against the reference model. Expect digit and digit_val to match the model and done to rise at exactly cycle 25535.
- Saturation: weights +127 and pixels 127 give acc ≥ 1024<<7, so act_addr=2047. Negative weights give act_addr=0.
- Argmax: output activations forced via the LUT to {-5, 40, 40, 12}, N_OUT=4. Expect digit=1, digit_val=40.
- Reset asserted mid HID_MAC at cycle 100. Expect busy=0, done=0, all addresses 0 immediately. A subsequent start completes normally.
- start pulsed during busy is ignored, with unchanged latency. start held high through DONE restarts the run: done pulses for 1 cycle, then busy=1.

Source files
------------

// File: rtl/nn_core_param_pkg.sv
// Shared types and constants for the parametrised two-layer inference core.
//   state_t    : controller states
//   ACT_LUT_AW : activation LUT address width
//   ACT_OFFSET : offset that maps the signed pre-activation onto a LUT address
//   MAX_INIT   : argmax register start value
//   PIX_ONE    : magnitude given to a set 1-bit pixel
package nn_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HID_MAC,
    HID_DRAIN,
    HID_ACT,
    HID_WR,
    OUT_MAC,
    OUT_DRAIN,
    OUT_ACT,
    OUT_CMP,
    DONE
  } state_t;

  localparam int unsigned      ACT_LUT_AW = 11;
  localparam int unsigned      ACT_OFFSET = 1024;
  localparam logic signed [7:0] MAX_INIT  = 8'sh80;
  localparam logic signed [7:0] PIX_ONE   = 8'sh7f;

endpackage

// File: rtl/nn_core_param_if.sv
// External memory bus of nn_core_param: pixel RAM, hidden/output weight ROMs
// and activation LUT. All memories are synchronous-read (data one cycle after
// the address).
//   master : the core (drives addresses, receives data)
//   slave  : the memory side
interface nn_core_param_if #(
  parameter int unsigned N_IN  = 784,
  parameter int unsigned N_HID = 32,
  parameter int unsigned N_OUT = 10,
  parameter int unsigned PIX_W = 1
);
  localparam int unsigned IA_W = $clog2(N_IN);
  localparam int unsigned HA_W = $clog2(N_IN * N_HID);
  localparam int unsigned OA_W = $clog2(N_HID * N_OUT);

  logic [IA_W-1:0]   in_addr;
  logic [PIX_W-1:0]  in_data;
  logic [HA_W-1:0]   hw_addr;
  logic signed [7:0] hw_data;
  logic [OA_W-1:0]   ow_addr;
  logic signed [7:0] ow_data;
  logic [10:0]       act_addr;
  logic signed [7:0] act_data;

  modport master (
    output in_addr, hw_addr, ow_addr, act_addr,
    input  in_data, hw_data, ow_data, act_data
  );

  modport slave (
    input  in_addr, hw_addr, ow_addr, act_addr,
    output in_data, hw_data, ow_data, act_data
  );
endinterface

// File: rtl/nn_core_param_mac_rect.sv
// Signed 8x8 multiply-accumulate with saturating LUT address generation.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : accumulate a*b this cycle
//   clr        : zero the accumulator (wins over en)
//   a, b       : signed 8-bit operands
//   act_addr   : sat11(acc >>> 7) + 1024, combinational from the accumulator
module nn_mac_rect
  import nn_pkg::*;
#(
  parameter int unsigned ACC_W = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic signed [7:0]     a,
  input  logic signed [7:0]     b,
  output logic [ACT_LUT_AW-1:0] act_addr
);
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(int'(ACT_OFFSET) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-int'(ACT_OFFSET));

  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      shifted;
  logic signed [15:0]           prod;
  logic signed [ACT_LUT_AW-1:0] sat;

  assign prod = a * b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + ACC_W'(prod);
  end

  assign shifted = acc >>> 7;

  always_comb begin
    sat = shifted[ACT_LUT_AW-1:0];
    if (shifted > S_MAX)      sat = S_MAX[ACT_LUT_AW-1:0];
    else if (shifted < S_MIN) sat = S_MIN[ACT_LUT_AW-1:0];
  end

  // Adding 1024 modulo 2048 to an 11-bit two's-complement value flips its MSB.
  assign act_addr = {~sat[ACT_LUT_AW-1], sat[ACT_LUT_AW-2:0]};

endmodule

// File: rtl/nn_core_param.sv
// Two-layer fully-connected inference engine: N_IN pixels -> N_HID hidden
// activations -> N_OUT output activations, reporting the signed argmax.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin inference (sampled in IDLE only)
//   mem        : pixel / weight / activation-LUT memory bus (master side)
//   busy       : inference in progress
//   done       : result valid, held until the next accepted start
//   digit      : argmax index (lowest index wins ties)
//   digit_val  : activation value at the argmax
module nn_core_param
  import nn_pkg::*;
#(
  parameter int unsigned N_IN  = 784,
  parameter int unsigned N_HID = 32,
  parameter int unsigned N_OUT = 10,
  parameter int unsigned PIX_W = 1,
  parameter int unsigned ACC_W = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  nn_core_param_if.master          mem,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N_OUT)-1:0] digit,
  output logic signed [7:0]        digit_val
);
  localparam int unsigned IA_W = $clog2(N_IN);
  localparam int unsigned HA_W = $clog2(N_IN * N_HID);
  localparam int unsigned OA_W = $clog2(N_HID * N_OUT);
  localparam int unsigned H_W  = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int unsigned O_W  = $clog2(N_OUT);

  localparam logic [IA_W-1:0] I_LAST = IA_W'(N_IN - 1);
  localparam logic [H_W-1:0]  H_LAST = H_W'(N_HID - 1);
  localparam logic [O_W-1:0]  O_LAST = O_W'(N_OUT - 1);

  state_t state, state_nxt;

  logic [IA_W-1:0]       in_addr_q;
  logic [HA_W-1:0]       hw_addr_q;
  logic [OA_W-1:0]       ow_addr_q;
  logic [H_W-1:0]        h_q;
  logic [O_W-1:0]        o_q;
  logic                  v_hid, v_out;
  logic signed [7:0]     hid_buf [N_HID];
  logic signed [7:0]     hid_q;
  logic signed [7:0]     max_q;
  logic [O_W-1:0]        idx_q;
  logic signed [7:0]     pix_ext, mac_a, mac_b;
  logic                  mac_en, mac_clr;
  logic [ACT_LUT_AW-1:0] act_raw;
  logic                  i_last, h_last, o_last;

  assign i_last = (in_addr_q == I_LAST);
  assign h_last = (h_q == H_LAST);
  assign o_last = (o_q == O_LAST);

  assign mem.in_addr = in_addr_q;
  assign mem.hw_addr = hw_addr_q;
  assign mem.ow_addr = ow_addr_q;
  // Address only presented during the ACT states so it idles (and resets) to 0.
  assign mem.act_addr = (state == HID_ACT || state == OUT_ACT) ? act_raw : '0;

  generate
    if (PIX_W == 1) begin : g_pix1
      assign pix_ext = mem.in_data[0] ? PIX_ONE : '0;
    end else begin : g_pixn
      assign pix_ext = 8'({1'b0, mem.in_data}) << (7 - PIX_W);
    end
  endgenerate

  // v_hid/v_out mark the cycle after an issue, when memory data is valid.
  assign mac_en  = v_hid | v_out;
  assign mac_a   = v_out ? hid_q : pix_ext;
  assign mac_b   = v_out ? mem.ow_data : mem.hw_data;
  assign mac_clr = (state == IDLE && start) || (state == HID_WR) || (state == OUT_CMP);

  nn_mac_rect #(.ACC_W(ACC_W)) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (mac_en),
    .clr      (mac_clr),
    .a        (mac_a),
    .b        (mac_b),
    .act_addr (act_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = HID_MAC;
      HID_MAC:   if (i_last) state_nxt = HID_DRAIN;
      HID_DRAIN: state_nxt = HID_ACT;
      HID_ACT:   state_nxt = HID_WR;
      HID_WR:    state_nxt = h_last ? OUT_MAC : HID_MAC;
      OUT_MAC:   if (h_last) state_nxt = OUT_DRAIN;
      OUT_DRAIN: state_nxt = OUT_ACT;
      OUT_ACT:   state_nxt = OUT_CMP;
      OUT_CMP:   state_nxt = o_last ? DONE : OUT_MAC;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_addr_q <= '0;
      hw_addr_q <= '0;
      ow_addr_q <= '0;
      h_q       <= '0;
      o_q       <= '0;
      v_hid     <= 1'b0;
      v_out     <= 1'b0;
      hid_q     <= '0;
      max_q     <= MAX_INIT;
      idx_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      digit     <= '0;
      digit_val <= '0;
    end else begin
      v_hid <= (state == HID_MAC);
      v_out <= (state == OUT_MAC);
      case (state)
        IDLE: if (start) begin
          in_addr_q <= '0;
          hw_addr_q <= '0;
          ow_addr_q <= '0;
          h_q       <= '0;
          o_q       <= '0;
          max_q     <= MAX_INIT;
          idx_q     <= '0;
          busy      <= 1'b1;
          done      <= 1'b0;
        end
        HID_MAC: begin
          in_addr_q <= i_last ? '0 : in_addr_q + IA_W'(1);
          hw_addr_q <= (i_last && h_last) ? '0 : hw_addr_q + HA_W'(1);
        end
        HID_WR: h_q <= h_last ? '0 : h_q + H_W'(1);
        OUT_MAC: begin
          hid_q     <= hid_buf[h_q];
          h_q       <= h_last ? '0 : h_q + H_W'(1);
          ow_addr_q <= (h_last && o_last) ? '0 : ow_addr_q + OA_W'(1);
        end
        OUT_CMP: begin
          if (mem.act_data > max_q) begin
            max_q <= mem.act_data;
            idx_q <= o_q;
          end
          o_q <= o_last ? '0 : o_q + O_W'(1);
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          digit     <= idx_q;
          digit_val <= max_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == HID_WR) hid_buf[h_q] <= mem.act_data;
  end

endmodule

// File: tb/tb_nn_core_param.sv
// Self-checking bench for nn_core_param with a small configuration.
// Expected LUT addresses and results come from a behavioural model and are
// queued when a start is accepted; they are popped at the cycles where the
// core must present them.
module tb_nn_core_param;
  localparam int unsigned N_IN  = 16;
  localparam int unsigned N_HID = 4;
  localparam int unsigned N_OUT = 4;
  localparam int unsigned PIX_W = 1;
  localparam int unsigned ACC_W = 26;
  localparam int B = int'(N_HID * (N_IN + 3));
  localparam int L = B + int'(N_OUT * (N_HID + 3)) + 1;

  typedef struct {
    int digit;
    int val;
  } res_t;

  logic clk = 1'b0;
  logic rst_n, start, busy, done;
  logic [$clog2(N_OUT)-1:0] digit;
  logic signed [7:0] digit_val;

  nn_core_param_if #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .PIX_W(PIX_W)) bus ();

  nn_core_param #(
    .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .PIX_W(PIX_W), .ACC_W(ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem       (bus),
    .busy      (busy),
    .done      (done),
    .digit     (digit),
    .digit_val (digit_val)
  );

  always #5 clk = ~clk;

  logic [PIX_W-1:0]  pix_m [N_IN];
  logic signed [7:0] hw_m  [N_IN*N_HID];
  logic signed [7:0] ow_m  [N_HID*N_OUT];
  logic signed [7:0] lut_m [2048];

  always @(posedge clk) begin
    bus.in_data  <= pix_m[bus.in_addr];
    bus.hw_data  <= hw_m[bus.hw_addr];
    bus.ow_data  <= ow_m[bus.ow_addr];
    bus.act_data <= lut_m[bus.act_addr];
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int lut_addr(longint acc);
    longint s;
    s = acc >>> 7;
    if (s > 1023) s = 1023;
    if (s < -1024) s = -1024;
    return int'(s) + 1024;
  endfunction

  int   addr_q [$];
  res_t res_q  [$];

  task automatic push_model();
    longint acc;
    int a, mx, mi;
    int hid [N_HID];
    for (int h = 0; h < int'(N_HID); h++) begin
      acc = 0;
      for (int i = 0; i < int'(N_IN); i++)
        acc += (pix_m[i][0] ? 127 : 0) * int'(hw_m[h*N_IN+i]);
      a = lut_addr(acc);
      addr_q.push_back(a);
      hid[h] = int'(lut_m[a]);
    end
    mx = -128;
    mi = 0;
    for (int o = 0; o < int'(N_OUT); o++) begin
      acc = 0;
      for (int h = 0; h < int'(N_HID); h++)
        acc += hid[h] * int'(ow_m[o*N_HID+h]);
      a = lut_addr(acc);
      addr_q.push_back(a);
      if (int'(lut_m[a]) > mx) begin
        mx = int'(lut_m[a]);
        mi = o;
      end
    end
    res_q.push_back('{digit: mi, val: mx});
  endtask

  function automatic bit is_hid_act(int c);
    return c < B && (c % int'(N_IN + 3)) == int'(N_IN) + 1;
  endfunction

  function automatic bit is_out_act(int c);
    return c >= B && c < L - 1 && ((c - B) % int'(N_HID + 3)) == int'(N_HID) + 1;
  endfunction

  // Run tracker: cyc counts posedges since the start-sampling edge.
  bit running = 1'b0;
  bit pend    = 1'b0;
  bit early   = 1'b0;
  int cyc     = 0;

  always begin
    int   e;
    res_t r;
    @(posedge clk);
    if (!rst_n) begin
      running = 1'b0;
      pend    = 1'b0;
      addr_q.delete();
      res_q.delete();
    end else if (running) begin
      cyc++;
      if (cyc == L) begin
        running = 1'b0;
        pend    = 1'b1;
      end
    end else if (start) begin
      running = 1'b1;
      cyc     = 0;
      push_model();
    end
    @(negedge clk);
    if (running) begin
      if (cyc == 0) begin
        early = 1'b0;
        check("busy_rise", busy, 1);
      end
      if (done) early = 1'b1;
      if (is_hid_act(cyc) || is_out_act(cyc)) begin
        e = (addr_q.size() > 0) ? addr_q.pop_front() : -1;
        check(is_hid_act(cyc) ? "hid_act_addr" : "out_act_addr", bus.act_addr, e);
      end
    end
    if (pend) begin
      pend = 1'b0;
      r = (res_q.size() > 0) ? res_q.pop_front() : '{digit: -1, val: -999};
      check("done_latency", done, 1);
      check("busy_fall", busy, 0);
      check("no_early_done", early, 0);
      check("digit", digit, r.digit);
      check("digit_val", digit_val, r.val);
      check("in_addr_wrap", bus.in_addr, 0);
      check("hw_addr_wrap", bus.hw_addr, 0);
      check("ow_addr_wrap", bus.ow_addr, 0);
      check("act_addr_idle", bus.act_addr, 0);
    end
  end

  task automatic lut_identity();
    for (int a = 0; a < 2048; a++) begin
      int v;
      v = a - 1024;
      lut_m[a] = 8'((v > 127) ? 127 : ((v < -128) ? -128 : v));
    end
  endtask

  task automatic fill_const(input int p, input int hw, input int ow);
    for (int i = 0; i < int'(N_IN); i++) pix_m[i] = PIX_W'(p);
    for (int k = 0; k < int'(N_IN*N_HID); k++) hw_m[k] = 8'(hw);
    for (int k = 0; k < int'(N_HID*N_OUT); k++) ow_m[k] = 8'(ow);
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int i = 0; i < int'(N_IN); i++) pix_m[i] = PIX_W'($urandom_range(0, 1));
    for (int k = 0; k < int'(N_IN*N_HID); k++) hw_m[k] = 8'(int'($urandom_range(0, hi - lo)) + lo);
    for (int k = 0; k < int'(N_HID*N_OUT); k++) ow_m[k] = 8'(int'($urandom_range(0, hi - lo)) + lo);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((running || pend || res_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", int'(running), 0);
  endtask

  task automatic run_once();
    pulse_start();
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int ws [4];
    int n;
    ws = '{-11, 64, 64, 20};
    rst_n = 1'b0;
    start = 1'b0;
    lut_identity();
    fill_const(1, 1, 1);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_digit", digit, 0);
    check("rst_digit_val", digit_val, 0);
    check("rst_in_addr", bus.in_addr, 0);
    check("rst_act_addr", bus.act_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // All ones: equal outputs, tie resolves to index 0.
    run_once();

    // Random data: small weights, full-range weights, random LUT.
    fill_rand(-20, 20);
    run_once();
    fill_rand(-128, 127);
    run_once();
    for (int a = 0; a < 2048; a++) lut_m[a] = 8'($urandom_range(0, 255));
    fill_rand(-40, 40);
    run_once();
    lut_identity();

    // Positive and negative saturation of the LUT address.
    fill_const(1, 127, 1);
    run_once();
    fill_const(1, -128, 1);
    run_once();

    // Argmax with forced output activations {-5, 40, 40, 12}.
    fill_const(1, 1, 1);
    for (int o = 0; o < int'(N_OUT); o++)
      for (int h = 0; h < int'(N_HID); h++) ow_m[o*N_HID+h] = 8'(ws[o]);
    lut_m[1018] = -8'sd5;
    lut_m[1054] = 8'sd40;
    lut_m[1033] = 8'sd12;
    run_once();

    // Reset in the middle of the hidden layer.
    pulse_start();
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_digit", digit, 0);
    check("mid_rst_digit_val", digit_val, 0);
    check("mid_rst_in_addr", bus.in_addr, 0);
    check("mid_rst_hw_addr", bus.hw_addr, 0);
    check("mid_rst_ow_addr", bus.ow_addr, 0);
    check("mid_rst_act_addr", bus.act_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_once();

    // Every output activation -128: index stays 0.
    for (int a = 0; a < 2048; a++) lut_m[a] = 8'sh80;
    run_once();
    lut_identity();

    // start during busy is ignored; latency checked by the tracker.
    fill_rand(-60, 60);
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    wait_idle();

    // start held through DONE: one-cycle done pulse, then a new run.
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 1000);
    check("held_done_seen", done, 1);
    @(negedge clk);
    check("held_done_drop", done, 0);
    check("held_busy_again", busy, 1);
    start = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
